aes_block_uart_tx: RTL
======================

Name: aes_block_uart_tx

Overview:
Downstream of the AES encryption core. Accepts one 128-bit ciphertext block with a valid/ready handshake and serializes it as 16 UART 8N1 frames on a single tx line. Feeds the board UART pin and completes the rx -> encrypt -> tx loop. Holds no queue: one block in flight at a time.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal values are >= 2.
NUM_BYTES, 16, bytes per block; the data width is 8*NUM_BYTES.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
blk_valid  input  1  blk_data holds a block to send
blk_data  input  128  block; byte [127:120] is sent first
blk_ready  output  1  high only in IDLE; transfer occurs when blk_valid && blk_ready
tx  output  1  UART serial out, idle high
busy  output  1  high from the cycle after acceptance until the cycle after done
done  output  1  one-cycle pulse at the end of the last stop bit

Behaviour:
- Reset (async, rst_n=0): tx=1, blk_ready=1, busy=0, done=0; state=IDLE; bit, byte and baud counters=0; shift register cleared. Asserting reset mid-frame aborts the block immediately and discards it.
- Acceptance cycle: blk_data is latched into a 128-bit shift register and state goes to START. tx falls on the next clock edge (latency 1).
- States:
  - IDLE -> START on accept.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles -> STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_cnt < NUM_BYTES-1: byte_cnt++, shift register left 8, go to START. Otherwise assert done for one cycle and go to IDLE.
- No idle gap between bytes within a block: STOP is followed directly by START.
- Each bit lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and wraps.
- Block length = NUM_BYTES*10*CLKS_PER_BIT cycles from the first start-bit cycle to done (11 bits/frame with parity).
- blk_ready returns high the cycle after done.
- blk_valid held high continuously: the next block is accepted that cycle, so there is exactly one extra idle-high cycle between blocks.
- blk_valid or blk_data changes while busy: ignored. The latched copy is transmitted unchanged.
- done and blk_ready are never high in the same cycle.

Optional Feature:
UART_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11 bits; block = NUM_BYTES*11*CLKS_PER_BIT cycles.
- Undefined: plain 8N1; the PARITY state and its logic are absent.

Decomposition:
- Package aes_uart_pkg holds:
  - AES_BLOCK_W=128 and UART_BYTE_W=8
  - the state typedef {IDLE, START, DATA, PARITY, STOP}
  - the default CLKS_PER_BIT constant
- One natural sub-module, uart_byte_tx: single-byte serializer with start/ack handshake and baud counter.
- aes_block_uart_tx keeps the block shift register, byte counter, valid/ready and done logic, and sequences uart_byte_tx.

Test Plan:
1. Reset: hold rst_n=0 for 5 cycles, including mid-clock -> tx=1, blk_ready=1, busy=0, done=0 throughout.
2. CLKS_PER_BIT=4; send blk_data=128'h29C3505F571420F6402299B31A02D73A -> bench UART monitor decodes bytes 29,C3,50,5F,57,14,20,F6,40,22,99,B3,1A,02,D7,3A in order. tx falls 1 cycle after accept. Every bit is 4 cycles wide. done pulses 640 cycles after the first start-bit cycle.
3. While busy, drive blk_valid=1 with 128'hFFFF...FF -> ignored, blk_ready stays 0, and the first block is transmitted intact. Keep valid high: the FF block is accepted the cycle after done and starts after one idle-high cycle.
4. Assert rst_n=0 during byte 5, data bit 3 -> tx=1 asynchronously. After release, blk_ready=1, and a new block 128'h0 transmits sixteen 00 bytes starting from byte 0.
5. CLKS_PER_BIT=2, 3 back-to-back blocks -> 3 done pulses spaced exactly 321 cycles apart, with no missing or duplicate bytes.
6. With UART_PARITY_EN, send byte 0x29 first -> frame is start 0, data 1,0,0,1,0,1,0,0, parity 1, stop 1. Block length is 704 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared constants and the UART frame state type for the AES ciphertext UART transmitter.
package aes_uart_pkg;

  localparam int AES_BLOCK_W          = 128;
  localparam int UART_BYTE_W          = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART serializer: start/data(LSB first)/stop, with optional even parity (UART_PARITY_EN).
// A start request seen in the last stop-bit cycle chains straight into the next frame.
module uart_byte_tx
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [UART_BYTE_W-1:0] data_i,
  output logic                   ack_o,
  output logic                   tx_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(UART_BYTE_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_BYTE_W - 1);

  uart_state_e            state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign tx_o    = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    ack_o   = 1'b0;
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = START;
          data_d  = data_i;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            bit_d = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          ack_o = 1'b1;
          if (start_i) begin
            state_d = START;
            data_d  = data_i;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is derived from the next state so tx leaves a flop, glitch-free.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
`ifdef UART_PARITY_EN
      PARITY:  tx_d = ^data_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/aes_block_uart_tx.sv
// Sends one AES ciphertext block as NUM_BYTES back-to-back UART frames, MSB byte first.
// Define UART_PARITY_EN for 8E1 frames; the default build is 8N1.
module aes_block_uart_tx
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int NUM_BYTES    = AES_BLOCK_W / UART_BYTE_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           blk_valid,
  input  logic [UART_BYTE_W*NUM_BYTES-1:0] blk_data,
  output logic                           blk_ready,
  output logic                           tx,
  output logic                           busy,
  output logic                           done
);

  localparam int BLK_W = UART_BYTE_W * NUM_BYTES;
  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BLK_W-1:0]       shift_q, shift_d;
  logic [BLK_W-1:0]       shifted;
  logic                   accept;
  logic                   last_byte;
  logic                   byte_start;
  logic [UART_BYTE_W-1:0] byte_data;
  logic                   byte_ack;

  assign shifted = shift_q << UART_BYTE_W;
  assign busy    = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // On each byte ack the next byte is handed over in the same cycle, so frames abut.
  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    blk_ready  = ~busy_q;
    accept     = blk_valid && !busy_q;
    last_byte  = (cnt_q == CNT_LAST);
    done       = 1'b0;
    byte_start = 1'b0;
    byte_data  = shifted[BLK_W-1 -: UART_BYTE_W];
    if (accept) begin
      busy_d     = 1'b1;
      cnt_d      = '0;
      shift_d    = blk_data;
      byte_start = 1'b1;
      byte_data  = blk_data[BLK_W-1 -: UART_BYTE_W];
    end else if (busy_q && byte_ack) begin
      if (last_byte) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end else begin
        cnt_d      = cnt_q + 1'b1;
        shift_d    = shifted;
        byte_start = 1'b1;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(byte_start),
    .data_i (byte_data),
    .ack_o  (byte_ack),
    .tx_o   (tx)
  );

endmodule
